// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RV32I control path.
// Optional INSTRET_COUNTER_EN build macro is consumed by the interface and top.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        WAIT,
        FETCH,
        DECODE,
        MEMADR,
        MEMREAD,
        MEMWB,
        MEMWRITE,
        EXECR,
        EXECI,
        ALUWB,
        BEQ,
        JAL,
        TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_MEMDATA   = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and the datapath.
// instret exists only when INSTRET_COUNTER_EN is defined.
interface multicycle_controller_if;

    logic [6:0]  op;
    logic        zero;
    logic        mem_ready;
    logic        pc_write;
    logic        adr_src;
    logic        mem_req;
    logic        mem_write;
    logic        ir_write;
    logic [1:0]  result_src;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic [1:0]  imm_src;
    logic        reg_write;
    logic        illegal_instr;
`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret;
`endif

    modport master (
        input  op, zero, mem_ready,
`ifdef INSTRET_COUNTER_EN
        output instret,
`endif
        output pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_instr
    );

    modport slave (
        output op, zero, mem_ready,
`ifdef INSTRET_COUNTER_EN
        input  instret,
`endif
        input  pc_write, adr_src, mem_req, mem_write, ir_write, result_src,
               alu_src_a, alu_src_b, alu_op, imm_src, reg_write, illegal_instr
    );

endinterface

// File: rtl/multicycle_controller_imm_src_decoder.sv
// Opcode to immediate-format select; kept separate so the pipelined core can reuse it.
module imm_src_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            default:   imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core.
// Build macro INSTRET_COUNTER_EN adds the retired-instruction counter.
//
// state    | meaning
// WAIT     | post-reset idle, RESET_WAIT cycles
// FETCH    | read instruction, PC <= PC+4 on mem_ready
// DECODE   | branch target precompute, dispatch on op
// MEMADR   | rs1 + imm address calculation
// MEMREAD  | load access, held until mem_ready
// MEMWB    | load data to rd
// MEMWRITE | store access, held until mem_ready
// EXECR    | register-register ALU op
// EXECI    | register-immediate ALU op
// ALUWB    | ALU result register to rd
// BEQ      | compare, take branch on zero
// JAL      | jump, compute PC+4 for rd
// TRAP     | unsupported opcode, exits only through rst
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned RESET_WAIT = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    multicycle_controller_if.master   bus
);

    localparam logic [3:0] WAIT_LOAD = (RESET_WAIT > 0) ? 4'(RESET_WAIT - 1) : 4'd0;
    localparam state_t     RST_STATE = (RESET_WAIT > 0) ? WAIT : FETCH;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       mem_is_store;

    logic       branch;
    logic       pc_update;
    logic       adr_src;
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_instr;
    logic [1:0] imm_dec;

`ifdef INSTRET_COUNTER_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWRITE) && bus.mem_ready);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RST_STATE;
            wait_cnt     <= WAIT_LOAD;
            mem_is_store <= 1'b0;
`ifdef INSTRET_COUNTER_EN
            instret_q    <= 32'd0;
`endif
        end else begin
`ifdef INSTRET_COUNTER_EN
            if (retire) instret_q <= instret_q + 32'd1;
`endif
            case (state)
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= FETCH;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                FETCH:    if (bus.mem_ready) state <= DECODE;
                DECODE: begin
                    // latch load/store choice so MEMADR does not depend on op later
                    mem_is_store <= (bus.op == OP_STORE);
                    case (bus.op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_RTYPE:          state <= EXECR;
                        OP_ITYPE:          state <= EXECI;
                        OP_BRANCH:         state <= BEQ;
                        OP_JAL:            state <= JAL;
                        default:           state <= TRAP;
                    endcase
                end
                MEMADR:   state <= mem_is_store ? MEMWRITE : MEMREAD;
                MEMREAD:  if (bus.mem_ready) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (bus.mem_ready) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BEQ:      state <= FETCH;
                JAL:      state <= ALUWB;
                TRAP:     state <= TRAP;
                default:  state <= FETCH;
            endcase
        end
    end

    // Moore decode; everything forced low while rst is asserted
    always_comb begin
        branch        = 1'b0;
        pc_update     = 1'b0;
        adr_src       = 1'b0;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        result_src    = RES_ALUOUT;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALUOP_ADD;
        reg_write     = 1'b0;
        illegal_instr = 1'b0;
        if (!rst) begin
            case (state)
                FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALURESULT;
                    ir_write   = bus.mem_ready;
                    pc_update  = bus.mem_ready;
                end
                DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                MEMADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                MEMREAD: begin
                    adr_src = 1'b1;
                    mem_req = 1'b1;
                end
                MEMWB: begin
                    result_src = RES_MEMDATA;
                    reg_write  = 1'b1;
                end
                MEMWRITE: begin
                    adr_src   = 1'b1;
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                end
                EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_FUNCT;
                end
                EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALUOP_FUNCT;
                end
                ALUWB: reg_write = 1'b1;
                BEQ: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_RS2;
                    alu_op    = ALUOP_SUB;
                    branch    = 1'b1;
                end
                JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_update = 1'b1;
                end
                TRAP:    illegal_instr = 1'b1;
                default: ;
            endcase
        end
    end

    imm_src_decoder u_imm_src_decoder (
        .op      (bus.op),
        .imm_src (imm_dec)
    );

    assign bus.pc_write      = (branch & bus.zero) | pc_update;
    assign bus.adr_src       = adr_src;
    assign bus.mem_req       = mem_req;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.result_src    = result_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.imm_src       = rst ? 2'b00 : imm_dec;
    assign bus.reg_write     = reg_write;
    assign bus.illegal_instr = illegal_instr;
`ifdef INSTRET_COUNTER_EN
    assign bus.instret       = instret_q;
`endif

endmodule
